clock_tick_controller: RTL and testbench
========================================

CLOCK_TICK_CONTROLLER -- requirements
Module: clock_tick_controller

Interface
REQ-001 SHALL have parameter N, default 26, counter and configuration width in bits.
REQ-002 SHALL have parameter DEFAULT_HALF, default 49999999, terminal count loaded at reset (100 MHz to 1 Hz).
REQ-003 SHALL have port CP_100MHz, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1, level sampled each cycle: run request.
REQ-006 SHALL have port Stop, input, 1, level sampled each cycle: pause request.
REQ-007 SHALL have port Step, input, 1, level sampled each cycle: single half-period request.
REQ-008 SHALL have port Cfg_Valid, input, 1, new terminal count offered.
REQ-009 SHALL have port Cfg_Half, input, N, offered terminal count; half-period = Cfg_Half+1 cycles.
REQ-010 SHALL have port Cfg_Ready, output, 1, high when the shadow register is empty.
REQ-011 SHALL have port CP_Out, output, 1, divided clock, registered.
REQ-012 SHALL have port Tick, output, 1, registered one-cycle pulse coincident with every CP_Out toggle.
REQ-013 SHALL have port State, output, 2, current FSM state encoding.

Function
REQ-014 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2, STEP=3.
REQ-015 In IDLE, counter SHALL hold 0, CP_Out 0, Tick 0; Start moves to RUN, Stop and Step are ignored.
REQ-016 In RUN and STEP, counter SHALL increment by 1 each cycle while count < half_reg.
REQ-017 When count == half_reg in RUN/STEP, SHALL clear counter, invert CP_Out, and drive Tick=1 on the same edge.
REQ-018 In RUN, Stop SHALL move to PAUSE; counter and CP_Out SHALL freeze at current values.
REQ-019 In PAUSE, Start SHALL return to RUN and resume from the frozen count; Step SHALL move to STEP.
REQ-020 In STEP, on the toggle edge the FSM SHALL return to PAUSE; exactly one toggle per Step.
REQ-021 Simultaneous requests SHALL resolve with priority Stop > Start > Step.
REQ-022 Stop in STEP SHALL abort to PAUSE without toggling.
REQ-023 Cfg_Valid && Cfg_Ready SHALL capture Cfg_Half into the shadow register and set pending; Cfg_Ready drops the next cycle.
REQ-024 Cfg_Valid while Cfg_Ready=0 SHALL be ignored; the offer must be held until accepted.
REQ-025 In IDLE or PAUSE, pending SHALL apply on the next edge: half_reg <= shadow, counter <= 0, pending cleared.
REQ-026 In RUN or STEP, pending SHALL apply only on a toggle edge, so the following half-period uses the new value; the in-progress half-period is never shortened or lengthened.
REQ-027 Capture and apply in the same cycle SHALL NOT occur; Cfg_Ready SHALL rise the cycle after apply.
REQ-028 Cfg_Half=0 SHALL be legal: CP_Out toggles every cycle and Tick stays high continuously.
REQ-029 Counter arithmetic SHALL be N-bit unsigned; the counter never exceeds half_reg, so no wrap beyond the terminal count is possible.

Reset
REQ-030 CLR=1 at a rising edge SHALL force State=IDLE, counter=0, CP_Out=0, Tick=0, half_reg=DEFAULT_HALF, pending=0, Cfg_Ready=1.
REQ-031 CLR SHALL take precedence over all other inputs, including mid-period and mid-handshake; any pending shadow value is discarded.
REQ-032 No asynchronous reset path SHALL exist.

Structure
REQ-033 State encodings and DEFAULT_HALF SHALL live in shared package clock_tick_pkg.
REQ-034 Counter and toggle logic SHALL be one sub-module, tick_counter (ports: clock, reset, enable, clear, load, half, CP_Out, Tick); the FSM and handshake stay in the top.

Verification (N=8, DEFAULT_HALF=3)
REQ-035 CLR for 2 cycles, then Start -> State=RUN next cycle; CP_Out toggles every 4 cycles with a one-cycle Tick on each toggle.
REQ-036 Stop at count=2, hold 10 cycles, then Start -> no toggle during PAUSE; next toggle exactly 2 cycles after resume.
REQ-037 In PAUSE, pulse Step -> exactly one toggle 4 cycles later, then State=PAUSE; Stop+Start+Step together in RUN -> PAUSE.
REQ-038 In RUN, offer Cfg_Half=7 at count=1 -> accepted, Cfg_Ready=0; current half-period stays 4 cycles, following ones are 8 cycles; Cfg_Ready returns high after the toggle.
REQ-039 Cfg_Half=0 in PAUSE, then Start -> CP_Out toggles every cycle and Tick held at 1.
REQ-040 CLR asserted mid-period with a pending config -> all outputs reset per REQ-030; after Start the period is again 4 cycles.

Source files
------------

// File: rtl/clock_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_tick_pkg
// Description : Shared constants and FSM state encoding for the clock tick
//               controller and its counter sub-block.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_tick_pkg;

    // Counter width and reset terminal count (100 MHz down to 1 Hz)
    localparam int          c_DEFAULT_N    = 26;
    localparam int unsigned c_DEFAULT_HALF = 49999999;

    // Controller states; encoding is visible on the State output
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter
// Description : Half-period counter with divided-clock toggle and tick pulse.
//               Holds the active terminal count; a load while counting is
//               only issued by the controller on a terminal edge, so the
//               half-period in progress is never disturbed.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_counter
    import clock_tick_pkg::*;
#(
    parameter int          N            = c_DEFAULT_N,
    parameter int unsigned DEFAULT_HALF = c_DEFAULT_HALF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] half,
    output logic         CP_Out,
    output logic         Tick,
    output logic         terminal
);

    logic [N-1:0] r_count;
    logic [N-1:0] r_half;
    logic         r_cp_out;
    logic         r_tick;

    // Terminal count reached: this edge ends the current half-period if counting
    assign terminal = (r_count == r_half);

    // Count, toggle the divided clock and pulse Tick on each toggle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_half   <= N'(DEFAULT_HALF);
            r_cp_out <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (load) begin
                r_half <= half;
            end
            if (clear) begin
                r_count  <= '0;
                r_cp_out <= 1'b0;
            end else if (enable) begin
                if (terminal) begin
                    r_count  <= '0;
                    r_cp_out <= ~r_cp_out;
                    r_tick   <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (load) begin
                // New terminal count applied while stopped restarts the period
                r_count <= '0;
            end
        end
    end

    assign CP_Out = r_cp_out;
    assign Tick   = r_tick;

endmodule
`default_nettype wire

// File: rtl/clock_tick_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_tick_controller
// Description : Run/pause/single-step controller for a programmable clock
//               divider, with a one-entry shadow register for terminal-count
//               updates via a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_tick_controller
    import clock_tick_pkg::*;
#(
    parameter int          N            = c_DEFAULT_N,
    parameter int unsigned DEFAULT_HALF = c_DEFAULT_HALF
) (
    input  logic         CP_100MHz,
    input  logic         CLR,
    input  logic         Start,
    input  logic         Stop,
    input  logic         Step,
    input  logic         Cfg_Valid,
    input  logic [N-1:0] Cfg_Half,
    output logic         Cfg_Ready,
    output logic         CP_Out,
    output logic         Tick,
    output logic [1:0]   State
);

    state_t       r_state;
    logic         r_pending;
    logic [N-1:0] r_shadow;

    logic         w_enable;
    logic         w_stopped;
    logic         w_terminal;
    logic         w_capture;
    logic         w_apply;

    // Counting happens in RUN and STEP unless Stop (highest priority) freezes it
    assign w_enable  = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !Stop;
    assign w_stopped = (r_state == ST_IDLE) || (r_state == ST_PAUSE);

    // Capture needs an empty shadow; apply needs a full one, so they never coincide
    assign w_capture = Cfg_Valid && !r_pending;
    assign w_apply   = r_pending && (w_stopped || (w_enable && w_terminal));

    tick_counter #(
        .N            (N),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_tick_counter (
        .clock    (CP_100MHz),
        .reset    (CLR),
        .enable   (w_enable),
        .clear    (r_state == ST_IDLE),
        .load     (w_apply),
        .half     (r_shadow),
        .CP_Out   (CP_Out),
        .Tick     (Tick),
        .terminal (w_terminal)
    );

    // Run/pause/step sequencing and shadow-register handshake
    always_ff @(posedge CP_100MHz) begin
        if (CLR) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_shadow  <= '0;
        end else begin
            if (w_capture) begin
                r_shadow  <= Cfg_Half;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (Start) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (Stop) r_state <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (Stop)       r_state <= ST_PAUSE;
                    else if (Start) r_state <= ST_RUN;
                    else if (Step)  r_state <= ST_STEP;
                end
                ST_STEP: begin
                    // Stop aborts without a toggle; otherwise leave after the one toggle
                    if (Stop || w_terminal) r_state <= ST_PAUSE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Cfg_Ready = !r_pending;
    assign State     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clock_tick_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_tick_controller
// Description : Self-checking bench for clock_tick_controller (N=8, half=3).
//               Directed table, hand-written corner sequences and random
//               traffic, all checked against a remaining-cycles model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_tick_controller;

    localparam int N    = 8;
    localparam int DH   = 3;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_STEP  = 3;

    logic         clk;
    logic         CLR, Start, Stop, Step, Cfg_Valid;
    logic [N-1:0] Cfg_Half;
    logic         Cfg_Ready, CP_Out, Tick;
    logic [1:0]   State;

    int vectors;
    int miscompares;

    // Reference model: mode, cycles left in the current half-period, outputs
    int m_mode, m_rem, m_out, m_tick, m_half, m_shadow, m_pend;

    clock_tick_controller #(.N(N), .DEFAULT_HALF(DH)) dut (
        .CP_100MHz (clk),
        .CLR       (CLR),
        .Start     (Start),
        .Stop      (Stop),
        .Step      (Step),
        .Cfg_Valid (Cfg_Valid),
        .Cfg_Half  (Cfg_Half),
        .Cfg_Ready (Cfg_Ready),
        .CP_Out    (CP_Out),
        .Tick      (Tick),
        .State     (State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr, start, stop, step, valid;
        logic [7:0] cfg;
        logic [1:0] st;
        logic       out, tick, rdy;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic [4:0] in, input logic [7:0] cfg,
                                input logic [1:0] st, input logic [2:0] ex);
        vec_t v;
        {v.clr, v.start, v.stop, v.step, v.valid} = in;
        v.cfg = cfg;
        v.st  = st;
        {v.out, v.tick, v.rdy} = ex;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge
    task automatic cyc(input logic clr, input logic start, input logic stop,
                       input logic step, input logic valid, input logic [7:0] cfg);
        bit counting, toggle, cap, app;
        int nhalf;
        CLR = clr; Start = start; Stop = stop; Step = step;
        Cfg_Valid = valid; Cfg_Half = cfg;
        if (clr) begin
            m_mode = M_IDLE; m_rem = DH + 1; m_out = 0; m_tick = 0;
            m_half = DH; m_shadow = 0; m_pend = 0;
        end else begin
            counting = ((m_mode == M_RUN) || (m_mode == M_STEP)) && !stop;
            toggle   = counting && (m_rem == 1);
            cap      = valid && (m_pend == 0);
            app      = (m_pend != 0) && ((m_mode == M_IDLE) || (m_mode == M_PAUSE) || toggle);
            nhalf    = app ? m_shadow : m_half;
            m_tick   = toggle ? 1 : 0;
            if (toggle) begin
                m_out = 1 - m_out;
                m_rem = nhalf + 1;
            end else if (app) begin
                m_rem = nhalf + 1;
            end else if (counting) begin
                m_rem = m_rem - 1;
            end
            m_half = nhalf;
            case (m_mode)
                M_IDLE:  if (start) m_mode = M_RUN;
                M_RUN:   if (stop) m_mode = M_PAUSE;
                M_PAUSE: if (!stop && start) m_mode = M_RUN;
                         else if (!stop && step) m_mode = M_STEP;
                default: if (stop || toggle) m_mode = M_PAUSE;
            endcase
            if (cap) begin
                m_shadow = int'(cfg);
                m_pend   = 1;
            end else if (app) begin
                m_pend = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("model_state", int'(State), m_mode);
        chk("model_cp_out", int'(CP_Out), m_out);
        chk("model_tick", int'(Tick), m_tick);
        chk("model_cfg_ready", int'(Cfg_Ready), 1 - m_pend);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Count edges up to and including the next Tick, bounded
    task automatic measure(input string name, input int exp);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            idle_cyc();
            n++;
            if (Tick) seen = 1;
        end
        if (!seen) n = -1;
        chk(name, n, exp);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        CLR = 1'b1; Start = 1'b0; Stop = 1'b0; Step = 1'b0;
        Cfg_Valid = 1'b0; Cfg_Half = '0;

        // Directed table: reset, run period, pause, step, half=0, priority, reset
        tbl[0]  = mk(5'b10000, 8'd0, 2'd0, 3'b001);
        tbl[1]  = mk(5'b10000, 8'd0, 2'd0, 3'b001);
        tbl[2]  = mk(5'b00110, 8'd0, 2'd0, 3'b001);
        tbl[3]  = mk(5'b01000, 8'd0, 2'd1, 3'b001);
        tbl[4]  = mk(5'b00000, 8'd0, 2'd1, 3'b001);
        tbl[5]  = mk(5'b00000, 8'd0, 2'd1, 3'b001);
        tbl[6]  = mk(5'b00000, 8'd0, 2'd1, 3'b001);
        tbl[7]  = mk(5'b00000, 8'd0, 2'd1, 3'b111);
        tbl[8]  = mk(5'b00000, 8'd0, 2'd1, 3'b101);
        tbl[9]  = mk(5'b00000, 8'd0, 2'd1, 3'b101);
        tbl[10] = mk(5'b00000, 8'd0, 2'd1, 3'b101);
        tbl[11] = mk(5'b00000, 8'd0, 2'd1, 3'b011);
        tbl[12] = mk(5'b00100, 8'd0, 2'd2, 3'b001);
        tbl[13] = mk(5'b00000, 8'd0, 2'd2, 3'b001);
        tbl[14] = mk(5'b00010, 8'd0, 2'd3, 3'b001);
        tbl[15] = mk(5'b00000, 8'd0, 2'd3, 3'b001);
        tbl[16] = mk(5'b00000, 8'd0, 2'd3, 3'b001);
        tbl[17] = mk(5'b00000, 8'd0, 2'd3, 3'b001);
        tbl[18] = mk(5'b00000, 8'd0, 2'd2, 3'b111);
        tbl[19] = mk(5'b00000, 8'd0, 2'd2, 3'b101);
        tbl[20] = mk(5'b00001, 8'd0, 2'd2, 3'b100);
        tbl[21] = mk(5'b00000, 8'd0, 2'd2, 3'b101);
        tbl[22] = mk(5'b01000, 8'd0, 2'd1, 3'b101);
        tbl[23] = mk(5'b00000, 8'd0, 2'd1, 3'b011);
        tbl[24] = mk(5'b00000, 8'd0, 2'd1, 3'b111);
        tbl[25] = mk(5'b00000, 8'd0, 2'd1, 3'b011);
        tbl[26] = mk(5'b01110, 8'd0, 2'd2, 3'b001);
        tbl[27] = mk(5'b10000, 8'd0, 2'd0, 3'b001);

        for (int i = 0; i < 28; i++) begin
            cyc(tbl[i].clr, tbl[i].start, tbl[i].stop, tbl[i].step, tbl[i].valid, tbl[i].cfg);
            chk($sformatf("tbl%0d_state", i), int'(State), int'(tbl[i].st));
            chk($sformatf("tbl%0d_cp_out", i), int'(CP_Out), int'(tbl[i].out));
            chk($sformatf("tbl%0d_tick", i), int'(Tick), int'(tbl[i].tick));
            chk($sformatf("tbl%0d_cfg_ready", i), int'(Cfg_Ready), int'(tbl[i].rdy));
        end

        // Stop at count 2, hold 10 cycles, resume: toggle 2 edges later
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        idle_cyc();
        idle_cyc();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("pause_state", int'(State), M_PAUSE);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            chk("pause_hold_tick", int'(Tick), 0);
            chk("pause_hold_out", int'(CP_Out), 0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("resume_state", int'(State), M_RUN);
        idle_cyc();
        chk("resume_e1_tick", int'(Tick), 0);
        idle_cyc();
        chk("resume_e2_tick", int'(Tick), 1);
        chk("resume_e2_out", int'(CP_Out), 1);

        // Stop aborts a step without toggling; a fresh step finishes the period
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("step_state", int'(State), M_STEP);
        idle_cyc();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("step_abort_state", int'(State), M_PAUSE);
        chk("step_abort_tick", int'(Tick), 0);
        chk("step_abort_out", int'(CP_Out), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle_cyc();
        idle_cyc();
        chk("step2_early_tick", int'(Tick), 0);
        idle_cyc();
        chk("step2_tick", int'(Tick), 1);
        chk("step2_out", int'(CP_Out), 0);
        chk("step2_state", int'(State), M_PAUSE);

        // Config accepted mid-period: current period 4, following ones 8
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7);
        chk("cfg_accept_ready", int'(Cfg_Ready), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
        chk("cfg_busy_ready", int'(Cfg_Ready), 0);
        chk("cfg_busy_tick", int'(Tick), 0);
        idle_cyc();
        chk("cfg_old_period_tick", int'(Tick), 1);
        chk("cfg_ready_back", int'(Cfg_Ready), 1);
        measure("cfg_new_period_a", 8);
        measure("cfg_new_period_b", 8);

        // Reset mid-period with a pending config discards it
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        idle_cyc();
        idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("clr_state", int'(State), M_IDLE);
        chk("clr_out", int'(CP_Out), 0);
        chk("clr_tick", int'(Tick), 0);
        chk("clr_ready", int'(Cfg_Ready), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        measure("clr_period_a", 4);
        measure("clr_period_b", 4);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 10) == 0,
                ($urandom % 6) == 0, ($urandom % 5) == 0, 8'($urandom % 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
